// File: rtl/rcounter_commander_multi.sv
// Multi-channel min:sec:10ms countdown controller: CHANNELS timers share one
// five-button edit/run interface and one registered packed-BCD display port.
module rcounter_commander_multi #(
    parameter int  CHANNELS    = 4,
    parameter int  TICK_DIV    = 1000000,
    parameter int  MIN_MAX     = 99,
    parameter bit  AUTO_RELOAD = 1'b0,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_core,
    input  logic                rst,
    input  logic                left_button,
    input  logic                right_button,
    input  logic                up_button,
    input  logic                down_button,
    input  logic                center_button,
    input  logic [CH_W-1:0]     ch_sel,
    output logic [7:0]          min_o,
    output logic [7:0]          sec_o,
    output logic [7:0]          ms_10_o,
    output logic [1:0]          target,
    output logic [1:0]          state_o,
    output logic [CHANNELS-1:0] running_o,
    output logic [CHANNELS-1:0] time_out_o
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Times are kept as {min, sec, ms_10}, each field 7-bit binary.
    function automatic logic [20:0] dec_time(input logic [20:0] t);
        logic [6:0] mn;
        logic [6:0] sc;
        logic [6:0] ms;
        {mn, sc, ms} = t;
        if (ms != 7'd0) begin
            ms = ms - 7'd1;
        end else begin
            ms = 7'd99;
            if (sc != 7'd0) begin
                sc = sc - 7'd1;
            end else begin
                sc = 7'd59;
                mn = mn - 7'd1;
            end
        end
        return {mn, sc, ms};
    endfunction

    function automatic logic [6:0] step_field(input logic [6:0] f, input logic [6:0] mx,
                                              input logic up);
        logic [6:0] r;
        if (up) begin
            r = (f >= mx) ? 7'd0 : f + 7'd1;
        end else begin
            r = (f == 7'd0) ? mx : f - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    state_t              r_state [CHANNELS];
    logic [20:0]         r_cnt   [CHANNELS];
    logic [20:0]         r_pre   [CHANNELS];
    logic [CHANNELS-1:0] r_to;
    logic [PW-1:0]       r_presc;
    logic [4:0]          r_prev;
    logic [1:0]          r_target;

    logic [4:0]  w_btn;
    logic [4:0]  w_press;
    logic        w_tick;
    logic        w_sel_ok;
    logic        w_act_center;
    logic        w_act_up;
    logic        w_act_down;
    logic        w_act_left;
    logic        w_act_right;
    logic [20:0] w_sel_cnt;
    state_t      w_sel_state;
    logic [20:0] w_edit;

    assign w_btn    = {center_button, up_button, down_button, left_button, right_button};
    assign w_press  = w_btn & ~r_prev;
    assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
    assign w_sel_ok = ({{(32-CH_W){1'b0}}, ch_sel} < 32'(CHANNELS));

    // Pick the single highest-priority press; an unmapped channel acts on nothing.
    always_comb begin
        w_act_center = 1'b0;
        w_act_up     = 1'b0;
        w_act_down   = 1'b0;
        w_act_left   = 1'b0;
        w_act_right  = 1'b0;
        if (w_sel_ok) begin
            if (w_press[4])      w_act_center = 1'b1;
            else if (w_press[3]) w_act_up     = 1'b1;
            else if (w_press[2]) w_act_down   = 1'b1;
            else if (w_press[1]) w_act_left   = 1'b1;
            else if (w_press[0]) w_act_right  = 1'b1;
            else                 w_act_center = 1'b0;
        end else begin
            w_act_center = 1'b0;
        end
    end

    // View of the addressed channel; reads as zero/IDLE when ch_sel is out of range.
    always_comb begin
        w_sel_cnt   = 21'd0;
        w_sel_state = ST_IDLE;
        if (w_sel_ok) begin
            w_sel_cnt   = r_cnt[ch_sel];
            w_sel_state = r_state[ch_sel];
        end else begin
            w_sel_cnt   = 21'd0;
            w_sel_state = ST_IDLE;
        end
    end

    // Edited time: the target field stepped with wrap, no carry into neighbours.
    always_comb begin
        w_edit = w_sel_cnt;
        case (r_target)
            2'd0:    w_edit[6:0]   = step_field(w_sel_cnt[6:0], 7'd99, w_act_up);
            2'd1:    w_edit[13:7]  = step_field(w_sel_cnt[13:7], 7'd59, w_act_up);
            2'd2:    w_edit[20:14] = step_field(w_sel_cnt[20:14], 7'(MIN_MAX), w_act_up);
            default: w_edit        = w_sel_cnt;
        endcase
    end

    // Button history, shared prescaler, target field and per-channel timer FSMs.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_prev   <= 5'd0;
            r_presc  <= '0;
            r_target <= 2'd0;
            r_to     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= 21'd0;
                r_pre[i]   <= 21'd0;
            end
        end else begin
            r_prev  <= w_btn;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_act_left) begin
                r_target <= (r_target == 2'd2) ? 2'd0 : r_target + 2'd1;
            end else if (w_act_right) begin
                r_target <= (r_target == 2'd0) ? 2'd2 : r_target - 2'd1;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                // In reload mode the timeout flag is a single-cycle strobe.
                if (AUTO_RELOAD) r_to[i] <= 1'b0;
                if (w_act_center && (ch_sel == CH_W'(i))) begin
                    case (r_state[i])
                        ST_IDLE:  if (r_cnt[i] != 21'd0) r_state[i] <= ST_RUN;
                        ST_RUN:   r_state[i] <= ST_PAUSE;
                        ST_PAUSE: r_state[i] <= ST_RUN;
                        ST_DONE: begin
                            r_state[i] <= ST_IDLE;
                            r_cnt[i]   <= r_pre[i];
                            r_to[i]    <= 1'b0;
                        end
                        default:  r_state[i] <= ST_IDLE;
                    endcase
                end else if ((w_act_up || w_act_down) && (ch_sel == CH_W'(i))
                             && (r_state[i] == ST_IDLE)) begin
                    r_cnt[i] <= w_edit;
                    r_pre[i] <= w_edit;
                end else if ((r_state[i] == ST_RUN) && w_tick) begin
                    if (dec_time(r_cnt[i]) == 21'd0) begin
                        r_to[i] <= 1'b1;
                        if (AUTO_RELOAD) begin
                            r_cnt[i] <= r_pre[i];
                        end else begin
                            r_cnt[i]   <= 21'd0;
                            r_state[i] <= ST_DONE;
                        end
                    end else begin
                        r_cnt[i] <= dec_time(r_cnt[i]);
                    end
                end
            end
        end
    end

    // Registered display and status outputs.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            min_o      <= 8'd0;
            sec_o      <= 8'd0;
            ms_10_o    <= 8'd0;
            target     <= 2'd0;
            state_o    <= 2'd0;
            running_o  <= '0;
            time_out_o <= '0;
        end else begin
            min_o      <= to_bcd(w_sel_cnt[20:14]);
            sec_o      <= to_bcd(w_sel_cnt[13:7]);
            ms_10_o    <= to_bcd(w_sel_cnt[6:0]);
            target     <= r_target;
            state_o    <= w_sel_state;
            time_out_o <= r_to;
            for (int i = 0; i < CHANNELS; i++) begin
                running_o[i] <= (r_state[i] == ST_RUN);
            end
        end
    end

endmodule

// File: tb/tb_rcounter_commander_multi.sv
// Bench for rcounter_commander_multi: a hand-written vector table plus random
// stimulus against a model that keeps each timer as a total count of 10 ms units.
module tb_rcounter_commander_multi;
    localparam int TD = 4;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lb = 1'b0, rb = 1'b0, ub = 1'b0, db = 1'b0, cb = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [7:0] d_min, d_sec, d_ms, a_min, a_sec, a_ms;
    logic [1:0] d_tgt, d_st, d_run, d_to, a_tgt, a_st;
    logic [2:0] a_run, a_to;

    int errors = 0;
    int checks = 0;

    rcounter_commander_multi #(.CHANNELS(2), .TICK_DIV(TD), .MIN_MAX(99), .AUTO_RELOAD(1'b0)) dut (
        .clk_core(clk), .rst(rst), .left_button(lb), .right_button(rb), .up_button(ub),
        .down_button(db), .center_button(cb), .ch_sel(sel[0]), .min_o(d_min), .sec_o(d_sec),
        .ms_10_o(d_ms), .target(d_tgt), .state_o(d_st), .running_o(d_run), .time_out_o(d_to));

    rcounter_commander_multi #(.CHANNELS(3), .TICK_DIV(TD), .MIN_MAX(12), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk_core(clk), .rst(rst), .left_button(lb), .right_button(rb), .up_button(ub),
        .down_button(db), .center_button(cb), .ch_sel(sel), .min_o(a_min), .sec_o(a_sec),
        .ms_10_o(a_ms), .target(a_tgt), .state_o(a_st), .running_o(a_run), .time_out_o(a_to));

    always #5 clk = ~clk;

    // ---------------- reference model (model 0 = dut, model 1 = dut_ar) ----------------
    int m_cnt [2][3];
    int m_pre [2][3];
    int m_st  [2][3];
    bit m_to  [2][3];
    int m_tgt [2];
    int presc = 0;
    logic [4:0] prev = 5'd0;
    logic [33:0] expv [2];

    function automatic int nch(int m);  return (m == 0) ? 2 : 3;  endfunction
    function automatic int mmax(int m); return (m == 0) ? 99 : 12; endfunction
    function automatic int sel_of(int m); return (m == 0) ? int'(sel[0]) : int'(sel); endfunction
    function automatic logic [7:0] bcd(int v); return 8'((v / 10) * 16 + v % 10); endfunction

    function automatic logic [33:0] snap(int m);
        int s;
        logic [7:0] mn, sc, ms;
        logic [1:0] st;
        logic [2:0] run, to;
        s = sel_of(m);
        mn = 8'd0; sc = 8'd0; ms = 8'd0; st = 2'd0; run = 3'd0; to = 3'd0;
        if (s < nch(m)) begin
            mn = bcd(m_cnt[m][s] / 6000);
            sc = bcd((m_cnt[m][s] / 100) % 60);
            ms = bcd(m_cnt[m][s] % 100);
            st = 2'(m_st[m][s]);
        end
        for (int c = 0; c < nch(m); c++) begin
            run[c] = (m_st[m][c] == 1);
            to[c]  = m_to[m][c];
        end
        return {mn, sc, ms, 2'(m_tgt[m]), st, run, to};
    endfunction

    task automatic model_edge();
        logic [4:0] press;
        bit tick;
        int s, act, mn, sc, ms, fld, mx;
        for (int m = 0; m < 2; m++) expv[m] = rst ? 34'd0 : snap(m);
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_tgt[m] = 0;
                for (int c = 0; c < 3; c++) begin
                    m_cnt[m][c] = 0; m_pre[m][c] = 0; m_st[m][c] = 0; m_to[m][c] = 1'b0;
                end
            end
            presc = 0;
            prev  = 5'd0;
        end else begin
            press = {cb, ub, db, lb, rb} & ~prev;
            prev  = {cb, ub, db, lb, rb};
            tick  = (presc == TD - 1);
            presc = tick ? 0 : presc + 1;
            for (int m = 0; m < 2; m++) begin
                s = sel_of(m);
                act = -1;
                if (s < nch(m)) for (int b = 0; b < 5; b++) if (press[b]) act = b;
                if (act == 1) m_tgt[m] = (m_tgt[m] + 1) % 3;
                else if (act == 0) m_tgt[m] = (m_tgt[m] + 2) % 3;
                for (int c = 0; c < nch(m); c++) begin
                    if (m == 1) m_to[m][c] = 1'b0;
                    if (c == s && act == 4) begin
                        case (m_st[m][c])
                            0: if (m_cnt[m][c] != 0) m_st[m][c] = 1;
                            1: m_st[m][c] = 2;
                            2: m_st[m][c] = 1;
                            default: begin m_st[m][c] = 0; m_cnt[m][c] = m_pre[m][c]; m_to[m][c] = 1'b0; end
                        endcase
                    end else if (c == s && (act == 3 || act == 2) && m_st[m][c] == 0) begin
                        mn = m_cnt[m][c] / 6000;
                        sc = (m_cnt[m][c] / 100) % 60;
                        ms = m_cnt[m][c] % 100;
                        case (m_tgt[m])
                            0:       begin fld = ms; mx = 99; end
                            1:       begin fld = sc; mx = 59; end
                            default: begin fld = mn; mx = mmax(m); end
                        endcase
                        if (act == 3) fld = (fld == mx) ? 0 : fld + 1;
                        else          fld = (fld == 0) ? mx : fld - 1;
                        case (m_tgt[m])
                            0:       ms = fld;
                            1:       sc = fld;
                            default: mn = fld;
                        endcase
                        m_cnt[m][c] = mn * 6000 + sc * 100 + ms;
                        m_pre[m][c] = m_cnt[m][c];
                    end else if (m_st[m][c] == 1 && tick) begin
                        m_cnt[m][c] = m_cnt[m][c] - 1;
                        if (m_cnt[m][c] == 0) begin
                            m_to[m][c] = 1'b1;
                            if (m == 1) m_cnt[m][c] = m_pre[m][c];
                            else        m_st[m][c] = 3;
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [33:0] d_vec();
        return {d_min, d_sec, d_ms, d_tgt, d_st, 1'b0, d_run, 1'b0, d_to};
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("dut_vs_model", d_vec(), expv[0]);
        chk("dut_ar_vs_model", {a_min, a_sec, a_ms, a_tgt, a_st, a_run, a_to}, expv[1]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst;
        logic [4:0] btn;
        bit         sel;
        bit         chk;
        logic [7:0] ms;
        logic [7:0] sec;
        logic [1:0] tgt;
        logic [1:0] st;
        logic [1:0] run;
        logic [1:0] to;
    } vec_t;
    vec_t tv[$];

    task automatic add(bit r, logic [4:0] b, bit s, bit c, logic [7:0] ms, logic [7:0] sec,
                       logic [1:0] tgt, logic [1:0] st, logic [1:0] run, logic [1:0] to);
        vec_t v;
        v.rst = r; v.btn = b; v.sel = s; v.chk = c; v.ms = ms; v.sec = sec;
        v.tgt = tgt; v.st = st; v.run = run; v.to = to;
        tv.push_back(v);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) add(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0);
    endtask

    initial begin
        int last, npulse;
        // reset, three up presses, countdown to DONE, acknowledge
        add(1, 5'd0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, B_U,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h01, 8'h00, 0, 0, 0, 0);
        add(0, B_U,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h02, 8'h00, 0, 0, 0, 0);
        add(0, B_U,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0);
        add(0, B_C,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h03, 8'h00, 0, 1, 1, 0);
        add(0, 5'd0, 0, 1, 8'h02, 8'h00, 0, 1, 1, 0);
        idle(7);
        add(0, 5'd0, 0, 1, 8'h00, 8'h00, 0, 3, 0, 1);
        add(0, B_C,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0);
        // seconds edit with wrap, borrow on first tick, pause on a tick edge, resume
        add(1, 5'd0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, B_L,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        idle(1);
        add(0, B_D,  0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h00, 8'h59, 1, 0, 0, 0);
        add(0, B_C,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h00, 8'h59, 1, 1, 1, 0);
        idle(2);
        add(0, 5'd0, 0, 1, 8'h99, 8'h58, 1, 1, 1, 0);
        idle(2);
        add(0, B_C,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h99, 8'h58, 1, 2, 0, 0);
        add(0, B_C,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h99, 8'h58, 1, 1, 1, 0);
        idle(1);
        add(0, 5'd0, 0, 1, 8'h98, 8'h58, 1, 1, 1, 0);
        // channel 1: edit, then center+up together starts without incrementing; reset mid-run
        add(0, B_U,  1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 1, 1, 8'h00, 8'h01, 1, 0, 1, 0);
        add(0, B_C | B_U, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 1, 1, 8'h00, 8'h01, 1, 1, 3, 0);
        add(1, 5'd0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 5'd0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst;
            {cb, ub, db, lb, rb} = tv[i].btn;
            sel = {1'b0, tv[i].sel};
            cycle();
            if (tv[i].chk)
                chk($sformatf("vec%0d", i), d_vec(),
                    {8'h00, tv[i].sec, tv[i].ms, tv[i].tgt, tv[i].st, 1'b0, tv[i].run, 1'b0, tv[i].to});
        end

        // auto-reload: ch1 preset 00:00.02 pulses time_out_o[1] once every 2 ticks
        rst = 1'b1; {cb, ub, db, lb, rb} = 5'd0; cycle();
        rst = 1'b0; sel = 2'd1;
        ub = 1'b1; cycle(); ub = 1'b0; cycle();
        ub = 1'b1; cycle(); ub = 1'b0; cycle();
        cb = 1'b1; cycle(); cb = 1'b0; cycle();
        last = -1;
        npulse = 0;
        for (int i = 0; i < 48; i++) begin
            cycle();
            chk("ar_running", 34'(a_run[1]), 34'd1);
            if (a_to[1]) begin
                if (last >= 0) chk("ar_pulse_gap", 34'(i - last), 34'd8);
                last = i;
                npulse++;
            end
        end
        chk("ar_pulse_count", 34'(npulse >= 5), 34'd1);
        sel = 2'd0; cycle(); cycle();
        chk("ar_ch0_idle", {16'd0, a_st, a_ms, a_sec}, 34'd0);

        // random stimulus against the model
        rst = 1'b1; cycle();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            cb = ($urandom_range(0, 7) == 0);
            ub = ($urandom_range(0, 5) == 0);
            db = ($urandom_range(0, 7) == 0);
            lb = ($urandom_range(0, 9) == 0);
            rb = ($urandom_range(0, 9) == 0);
            sel = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
